// File: rtl/slab_alloc_pkg.sv
// rtl/slab_alloc_pkg.sv - shared request/response types for the slab allocator
package slab_alloc_pkg;

  // Widest byte address any configuration of the allocator may present.
  localparam int SLAB_ADDR_MAX_W = 32;

  typedef struct packed {
    logic [SLAB_ADDR_MAX_W-1:0] addr;
  } slab_free_req_struct;

  typedef struct packed {
    logic                       error;
    logic [SLAB_ADDR_MAX_W-1:0] addr;
  } slab_alloc_resp_struct;

  localparam int SLAB_FREE_REQ_STRUCT_W   = $bits(slab_free_req_struct);
  localparam int SLAB_ALLOC_RESP_STRUCT_W = $bits(slab_alloc_resp_struct);

  // Mask selecting the within-slab offset bits of a byte address.
  function automatic logic [SLAB_ADDR_MAX_W-1:0] slab_offset_mask(input int slab_bytes);
    return SLAB_ADDR_MAX_W'(slab_bytes - 1);
  endfunction

endpackage

// File: rtl/slab_free_fifo.sv
// rtl/slab_free_fifo.sv - reset-initialised circular FIFO of free slab indices
module slab_free_fifo
  import slab_alloc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W-1:0] LAST_PTR   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(DEPTH);

  logic [IDX_W-1:0] entry [DEPTH];
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Status flags and guarded push/pop: a full FIFO refuses pushes, an empty one ignores pops.
  always_comb begin
    full     = (count == FULL_COUNT);
    empty    = (count == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    head_idx = entry[rd_ptr];
  end

  // Reset loads every slab index in order; otherwise push/pop update pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= IDX_W'(i);
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= FULL_COUNT;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_idx;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/slab_alloc_tracker.sv
// rtl/slab_alloc_tracker.sv - free-list slab allocator; optional SLAB_ALLOC_ADDR_CHECK_EN free-address check
module slab_alloc_tracker
  import slab_alloc_pkg::*;
#(
  parameter int NUM_SLABS  = 8,
  parameter int SLAB_BYTES = 64,
  localparam int ADDR_W    = $clog2(NUM_SLABS * SLAB_BYTES),
  localparam int IDX_W     = $clog2(NUM_SLABS),
  localparam int OFF_W     = $clog2(SLAB_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_free_slab_req_val,
  input  logic [ADDR_W-1:0] src_free_slab_req_addr,
  output logic              free_slab_src_req_rdy,
  input  logic              src_alloc_slab_consume_val,
  output logic              alloc_slab_src_resp_error,
  output logic [ADDR_W-1:0] alloc_slab_src_resp_addr
);

  slab_free_req_struct   free_req;
  slab_alloc_resp_struct alloc_resp;

  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W:0]   count;
  logic             full;
  logic             empty;
  logic             free_fire;
  logic             push;
  logic             pop;

  // Free side: handshake whenever the list has room, convert byte address to slab index.
  always_comb begin
    free_req.addr         = SLAB_ADDR_MAX_W'(src_free_slab_req_addr);
    free_slab_src_req_rdy = ~full;
    free_fire             = src_free_slab_req_val & free_slab_src_req_rdy;
    push_idx              = IDX_W'(free_req.addr >> OFF_W);
  end

`ifdef SLAB_ALLOC_ADDR_CHECK_EN
  logic addr_bad;

  // Misaligned or out-of-range frees still complete the handshake but are dropped.
  always_comb begin
    addr_bad = ((free_req.addr & slab_offset_mask(SLAB_BYTES)) != '0) ||
               (free_req.addr >= SLAB_ADDR_MAX_W'(NUM_SLABS * SLAB_BYTES));
    push     = free_fire & ~addr_bad;
  end

  // Flag a dropped free so a caller bug is visible in simulation.
  always @(posedge clk) begin
    if (!rst && free_fire && addr_bad) begin
      $error("slab_alloc_tracker: bad free address 0x%0h discarded", free_req.addr);
    end
  end
`else
  // Every accepted free is pushed; offset bits are simply dropped.
  always_comb begin
    push = free_fire;
  end
`endif

  // Alloc side: present the head slab as a byte address, or error when nothing is free.
  always_comb begin
    pop                       = src_alloc_slab_consume_val & ~empty;
    alloc_resp.error          = empty;
    alloc_resp.addr           = empty ? '0 : (SLAB_ADDR_MAX_W'(head_idx) << OFF_W);
    alloc_slab_src_resp_error = alloc_resp.error;
    alloc_slab_src_resp_addr  = ADDR_W'(alloc_resp.addr);
  end

  slab_free_fifo #(
    .DEPTH (NUM_SLABS),
    .IDX_W (IDX_W)
  ) u_free_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (push_idx),
    .pop      (pop),
    .head_idx (head_idx),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_slab_alloc_tracker.sv
// tb/tb_slab_alloc_tracker.sv - table-driven and scoreboard bench for slab_alloc_tracker
module tb_slab_alloc_tracker;

  localparam int NS = 4;
  localparam int SB = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          free_val;
  logic [AW-1:0] free_addr;
  logic          free_rdy;
  logic          consume;
  logic          resp_error;
  logic [AW-1:0] resp_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          consume;
    logic          fval;
    logic [AW-1:0] faddr;
    logic          eerr;
    logic [AW-1:0] eaddr;
    logic          erdy;
  } vec_t;

  vec_t          tbl[$];
  logic [AW-1:0] model[$];

  slab_alloc_tracker #(
    .NUM_SLABS  (NS),
    .SLAB_BYTES (SB)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .src_free_slab_req_val      (free_val),
    .src_free_slab_req_addr     (free_addr),
    .free_slab_src_req_rdy      (free_rdy),
    .src_alloc_slab_consume_val (consume),
    .alloc_slab_src_resp_error  (resp_error),
    .alloc_slab_src_resp_addr   (resp_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic c, input logic fv, input int fa,
                              input logic ee, input int ea, input logic er);
    vec_t v;
    v.consume = c;
    v.fval    = fv;
    v.faddr   = AW'(fa);
    v.eerr    = ee;
    v.eaddr   = AW'(ea);
    v.erdy    = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard step: decide what the free list does this cycle, using the state before the edge.
  task automatic model_step(input logic c, input logic fv, input logic [AW-1:0] fa);
    logic          was_full;
    logic          ok;
    logic [AW-1:0] exp_addr;
    was_full = (model.size() == NS);
    if (c && model.size() > 0) begin
      exp_addr = model.pop_front();
      check("sb_alloc_addr", int'(resp_addr), int'(exp_addr));
    end
    ok = 1'b1;
`ifdef SLAB_ALLOC_ADDR_CHECK_EN
    if ((int'(fa) % SB) != 0) ok = 1'b0;
`endif
    if (fv && !was_full && ok) model.push_back(AW'((int'(fa) / SB) * SB));
  endtask

  initial begin
    rst       = 1'b1;
    free_val  = 1'b0;
    free_addr = '0;
    consume   = 1'b0;

    tbl.push_back(mk(0, 0,   0, 0,   0, 0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 0));
    tbl.push_back(mk(1, 0,   0, 0,   0, 0));
    tbl.push_back(mk(1, 0,   0, 0,  64, 1));
    tbl.push_back(mk(1, 0,   0, 0, 128, 1));
    tbl.push_back(mk(1, 0,   0, 0, 192, 1));
    tbl.push_back(mk(0, 0,   0, 1,   0, 1));
    tbl.push_back(mk(1, 0,   0, 1,   0, 1));
    tbl.push_back(mk(0, 1, 128, 1,   0, 1));
    tbl.push_back(mk(0, 0,   0, 0, 128, 1));
    tbl.push_back(mk(1, 0,   0, 0, 128, 1));
    tbl.push_back(mk(0, 0,   0, 1,   0, 1));
    tbl.push_back(mk(0, 1,  64, 1,   0, 1));
    tbl.push_back(mk(0, 1, 192, 0,  64, 1));
    tbl.push_back(mk(1, 0,   0, 0,  64, 1));
    tbl.push_back(mk(1, 0,   0, 0, 192, 1));
    tbl.push_back(mk(1, 1,  64, 1,   0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  64, 1));
    tbl.push_back(mk(0, 1, 128, 0,  64, 1));
    tbl.push_back(mk(1, 1,   0, 0,  64, 1));
    tbl.push_back(mk(1, 0,   0, 0, 128, 1));
    tbl.push_back(mk(1, 0,   0, 0,   0, 1));
    tbl.push_back(mk(0, 0,   0, 1,   0, 1));
`ifdef SLAB_ALLOC_ADDR_CHECK_EN
    tbl.push_back(mk(0, 1,  65, 1,   0, 1));
    tbl.push_back(mk(0, 1,  64, 1,   0, 1));
`else
    tbl.push_back(mk(0, 1,  65, 1,   0, 1));
`endif
    tbl.push_back(mk(0, 0,   0, 0,  64, 1));
    tbl.push_back(mk(0, 1,   0, 0,  64, 1));
    tbl.push_back(mk(0, 1, 128, 0,  64, 1));
    tbl.push_back(mk(0, 1, 192, 0,  64, 1));
    tbl.push_back(mk(0, 0,   0, 0,  64, 0));
    tbl.push_back(mk(1, 1, 128, 0,  64, 0));
    tbl.push_back(mk(0, 0,   0, 0,   0, 1));
    tbl.push_back(mk(1, 0,   0, 0,   0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 128, 1));

    for (int i = 0; i < NS; i++) model.push_back(AW'(i * SB));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      consume   = tbl[i].consume;
      free_val  = tbl[i].fval;
      free_addr = tbl[i].faddr;
      #1;
      check($sformatf("row%0d_error", i), int'(resp_error), int'(tbl[i].eerr));
      check($sformatf("row%0d_addr", i),  int'(resp_addr),  int'(tbl[i].eaddr));
      check($sformatf("row%0d_rdy", i),   int'(free_rdy),   int'(tbl[i].erdy));
      model_step(tbl[i].consume, tbl[i].fval, tbl[i].faddr);
      @(negedge clk);
    end
    consume  = 1'b0;
    free_val = 1'b0;
    #1;
    check("after_table_count", model.size(), 1);
    check("after_table_addr", int'(resp_addr), 192);

    // Reset in the middle of activity restores the full in-order list.
    @(negedge clk);
    consume = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    consume = 1'b0;
    model.delete();
    for (int i = 0; i < NS; i++) model.push_back(AW'(i * SB));
    #1;
    check("midreset_error", int'(resp_error), 0);
    check("midreset_addr",  int'(resp_addr),  0);
    check("midreset_rdy",   int'(free_rdy),   0);

    // Drain the whole list back-to-back via the scoreboard.
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      consume = 1'b1;
      #1;
      check($sformatf("drain%0d_error", i), int'(resp_error), 0);
      model_step(1'b1, 1'b0, '0);
      @(negedge clk);
    end
    consume = 1'b0;
    #1;
    check("drained_error", int'(resp_error), 1);
    check("drained_addr",  int'(resp_addr),  0);
    check("drained_rdy",   int'(free_rdy),   1);
    check("drained_model", model.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
